spi_reg_peripheral: RTL and testbench
=====================================

# spi_reg_peripheral

SPI target (mode 0, write-only) that receives 16-bit frames from an external controller and maintains the five 8-bit control registers consumed by the downstream PWM peripheral: output enables, PWM enables and the shared duty cycle. SPI pins arrive asynchronously on dedicated inputs and are synchronised into the system clock domain; all register updates happen in the `clk` domain. The block sits directly upstream of the PWM stage, and its register outputs wire straight to that stage's configuration inputs.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser; minimum 2.
- `MAX_ADDR`, 7'h04: highest writable register address; frames addressed above this are ignored.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sclk`  in  1  SPI clock; asynchronous to `clk`; idles low.
- `copi`  in  1  SPI controller-out data; asynchronous.
- `ncs`  in  1  SPI chip select, active-low; asynchronous.
- `en_reg_out_7_0`  out  8  register 0x00: output enables, bits 7:0.
- `en_reg_out_15_8`  out  8  register 0x01: output enables, bits 15:8.
- `en_reg_pwm_7_0`  out  8  register 0x02: PWM enables, bits 7:0.
- `en_reg_pwm_15_8`  out  8  register 0x03: PWM enables, bits 15:8.
- `pwm_duty_cycle`  out  8  register 0x04: duty cycle.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded for wrong length.

## Operation
- **Synchronisation**
  - Each of `sclk`, `copi` and `ncs` passes through `SYNC_STAGES` flops, plus one history flop.
  - Edges are detected on synchronised values:
    - `sclk_rise` = sync & ~hist.
    - `ncs_fall` and `ncs_rise` use the same pattern.
- **Frame format**, MSB first, 16 bits:
  - bit 15: R/W (1 = write).
  - bits 14:8: address.
  - bits 7:0: data.
- **States**
  - IDLE
    - `sclk` edges are ignored.
    - `ncs_fall` clears the shift register and the bit counter, then goes to SHIFT.
  - SHIFT
    - On `sclk_rise`: shift in synchronised `copi` at the LSB.
    - On `sclk_rise`: bit counter increments, saturating at 17. Any count of 17 or more marks overrun.
    - `ncs_rise` goes to COMMIT.
  - COMMIT, one cycle, then always IDLE:
    - Count == 16, bit 15 = 1 and address ≤ `MAX_ADDR`: write data to the addressed register and pulse `wr_strobe`.
    - Count == 16, and bit 15 = 0 or address > `MAX_ADDR`: frame silently ignored. No write, no pulse.
    - Count ≠ 16 (short or overrun): no write; pulse `frame_err`.
- **Simultaneous events**
  - `ncs_rise` and `sclk_rise` in the same cycle: `ncs_rise` wins and the `sclk` edge is not shifted.
  - `ncs_fall` while in COMMIT: the edge is lost and the frame that follows is not received. The controller must hold `ncs` high for ≥ `SYNC_STAGES`+3 `clk` cycles between frames.
- **Register rules**
  - Registers hold their value until written again.
  - Only one register changes per frame.
- **Reset**
  - All five registers = 8'h00, `wr_strobe` = 0, `frame_err` = 0.
  - State = IDLE; synchronisers and history flops cleared.
  - Reset mid-frame abandons the frame. Reception resumes only at the next `ncs_fall` after reset is released; an already-low `ncs` does not start a frame.

## Timing
- **Constraint**: `sclk` high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods. `copi` must be stable for that window around each `sclk` rising edge.
- **`ncs` latency**, with `SYNC_STAGES` = 2:
  - `ncs` pin rises before `clk` edge k.
  - `ncs_rise` is seen in the cycle after edge k+1; state is COMMIT after edge k+2.
  - Register and `wr_strobe` (or `frame_err`) are valid after edge k+3; the pulse drops after edge k+4.
  - General latency: `SYNC_STAGES`+2 edges.
- **`sclk` latency**: a shift occurs at edge k+2 after the pin rises before edge k.
- **Outputs**: all outputs are registered; there are no combinational paths from pins.

## Test plan
- **Basic write**
  - Stimulus: after reset, send 16'h80F0 (write, addr 0x00, data 0xF0).
  - Response: `en_reg_out_7_0` = 0xF0 exactly 4 edges after `ncs` rises; `wr_strobe` high for 1 cycle; other registers stay 0x00.
- **Full map**
  - Stimulus: send 0x81CC, 0x82AA, 0x8355, 0x8480 back-to-back, with minimum `ncs`-high gaps.
  - Response: registers 0x01–0x04 read CC/AA/55/80; four `wr_strobe` pulses.
- **Ignored frames**
  - Stimulus: send 0x00FF (read) and 0x8512 (addr 0x05).
  - Response: no register change; no `wr_strobe`; no `frame_err`.
- **Bad length**
  - Stimulus: send 15 bits of 0x80F0, then 17 bits.
  - Response: one `frame_err` pulse per frame; `en_reg_out_7_0` unchanged.
- **Reset mid-frame**
  - Stimulus: write 0x84FF, then start 0x8411 and assert `rst` after bit 8.
  - Response: `pwm_duty_cycle` = 0x00; the frame is discarded. A following full 0x8433 gives `pwm_duty_cycle` = 0x33.
- **Edge collision**
  - Stimulus: 16 bits, then a 17th `sclk` rise in the same `clk` cycle as `ncs` rises.
  - Response: count = 16; the write is committed.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI (mode 0) target that receives 16-bit frames and holds the
// five 8-bit PWM control registers. All SPI pins are synchronised into clk.
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int         NUM_REGS  = 5;
  localparam logic [4:0] FRAME_LEN = 5'd16;
  localparam logic [4:0] CNT_SAT   = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, copi_sync_reg, ncs_sync_reg;
  logic                   sclk_hist_reg, ncs_hist_reg;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt_reg;
  logic [7:0]  regs_reg [NUM_REGS];
  logic        wr_strobe_reg, frame_err_reg;

  logic        clear_frame, shift_en, commit_write, commit_err;
  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;

  // Input synchronisers plus one history flop per pin for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      copi_sync_reg <= '0;
      ncs_sync_reg  <= '0;
      sclk_hist_reg <= 1'b0;
      ncs_hist_reg  <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
      sclk_hist_reg <= sclk_s;
      ncs_hist_reg  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign copi_s    = copi_sync_reg[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_reg;
  assign ncs_rise  = ncs_s & ~ncs_hist_reg;
  assign ncs_fall  = ~ncs_s & ncs_hist_reg;

  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ncs_fall) state_next = SHIFT;
      SHIFT:   if (ncs_rise) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ncs_rise takes priority over a coincident sclk edge
  always_comb begin
    clear_frame  = 1'b0;
    shift_en     = 1'b0;
    commit_write = 1'b0;
    commit_err   = 1'b0;
    case (state_reg)
      IDLE:   clear_frame = ncs_fall;
      SHIFT:  shift_en    = sclk_rise & ~ncs_rise;
      COMMIT: begin
        if (bit_cnt_reg == FRAME_LEN) begin
          commit_write = shift_reg[15] && (frame_addr <= MAX_ADDR);
        end else begin
          commit_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (clear_frame) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[14:0], copi_s};
      if (bit_cnt_reg != CNT_SAT) begin
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= 8'h00;
      end
    end else begin
      wr_strobe_reg <= commit_write;
      frame_err_reg <= commit_err;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_write && frame_addr == 7'(i)) begin
          regs_reg[i] <= frame_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_reg[0];
  assign en_reg_out_15_8 = regs_reg[1];
  assign en_reg_pwm_7_0  = regs_reg[2];
  assign en_reg_pwm_15_8 = regs_reg[3];
  assign pwm_duty_cycle  = regs_reg[4];
  assign wr_strobe       = wr_strobe_reg;
  assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: bit-banged SPI frames, hand-computed
// register values, and pulse counting for wr_strobe / frame_err.
module tb_spi_reg_peripheral;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  int n_compared   = 0;
  int n_mismatched = 0;
  int strobe_cnt   = 0;
  int err_cnt      = 0;

  spi_reg_peripheral #(
    .SYNC_STAGES(2),
    .MAX_ADDR   (7'h04)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_strobe      (wr_strobe),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one cycle, so sampling once per negedge counts each exactly once
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
  end

  // Each SPI phase lasts 4 clk periods, above the 3-period minimum
  task automatic spi_bit(input logic b);
    copi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame_start();
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    ncs = 1'b1;
  endtask

  task automatic send_frame(input logic [16:0] val, input int n);
    frame_start();
    for (int i = n - 1; i >= 0; i--) spi_bit(val[i]);
    frame_end();
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    gap(4);
    n_compared++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
      n_mismatched++;
      $display("FAIL reset_regs: got %h want 0000000000",
               {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    n_compared++;
    if ({wr_strobe, frame_err} !== 2'b00) begin
      n_mismatched++;
      $display("FAIL reset_pulses: got %b want 00", {wr_strobe, frame_err});
    end
    $display("reset: regs=%h pulses=%b", {en_reg_out_7_0, pwm_duty_cycle}, {wr_strobe, frame_err});
  endtask

  task automatic test_basic_write();
    frame_start();
    for (int i = 15; i >= 0; i--) spi_bit(16'h80F0 >> i);
    frame_end();
    // ncs rose just before edge k; register lands after edge k+3
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (en_reg_out_7_0 !== 8'h00 || wr_strobe !== 1'b0) begin
      n_mismatched++;
      $display("FAIL basic_early: got reg=%h strobe=%b want 00/0", en_reg_out_7_0, wr_strobe);
    end
    @(negedge clk);
    n_compared++;
    if (en_reg_out_7_0 !== 8'hF0 || wr_strobe !== 1'b1) begin
      n_mismatched++;
      $display("FAIL basic_on_time: got reg=%h strobe=%b want f0/1", en_reg_out_7_0, wr_strobe);
    end
    @(negedge clk);
    n_compared++;
    if (wr_strobe !== 1'b0) begin
      n_mismatched++;
      $display("FAIL basic_strobe_drop: got %b want 0", wr_strobe);
    end
    n_compared++;
    if ({en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 32'h0) begin
      n_mismatched++;
      $display("FAIL basic_others: got %h want 00000000",
               {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    gap(4);
    $display("basic_write: frame 80f0 -> reg0=%h", en_reg_out_7_0);
  endtask

  task automatic test_full_map();
    int s0;
    s0 = strobe_cnt;
    send_frame(17'h081CC, 16); gap(5);
    send_frame(17'h082AA, 16); gap(5);
    send_frame(17'h08355, 16); gap(5);
    send_frame(17'h08480, 16); gap(8);
    n_compared++;
    if ({en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 32'hCCAA5580) begin
      n_mismatched++;
      $display("FAIL full_map_regs: got %h want ccaa5580",
               {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    n_compared++;
    if (strobe_cnt - s0 !== 4) begin
      n_mismatched++;
      $display("FAIL full_map_strobes: got %0d want 4", strobe_cnt - s0);
    end
    n_compared++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      n_mismatched++;
      $display("FAIL full_map_reg0_kept: got %h want f0", en_reg_out_7_0);
    end
    $display("full_map: regs1..4=%h strobes=%0d", {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, strobe_cnt - s0);
  endtask

  task automatic test_ignored();
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(17'h000FF, 16); gap(8);
    send_frame(17'h08512, 16); gap(8);
    n_compared++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF0CCAA5580) begin
      n_mismatched++;
      $display("FAIL ignored_regs: got %h want f0ccaa5580",
               {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    n_compared++;
    if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
      n_mismatched++;
      $display("FAIL ignored_pulses: got strobe=%0d err=%0d want 0/0", strobe_cnt - s0, err_cnt - e0);
    end
    $display("ignored: frames 00ff,8512 strobes=%0d errs=%0d", strobe_cnt - s0, err_cnt - e0);
  endtask

  task automatic test_bad_length();
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(17'h04078, 15); gap(8);   // first 15 bits of 80f0
    n_compared++;
    if (err_cnt - e0 !== 1) begin
      n_mismatched++;
      $display("FAIL short_err: got %0d want 1", err_cnt - e0);
    end
    send_frame(17'h101E1, 17); gap(8);   // 80f0 then one extra bit
    n_compared++;
    if (err_cnt - e0 !== 2) begin
      n_mismatched++;
      $display("FAIL long_err: got %0d want 2", err_cnt - e0);
    end
    n_compared++;
    if (en_reg_out_7_0 !== 8'hF0 || strobe_cnt - s0 !== 0) begin
      n_mismatched++;
      $display("FAIL bad_len_nowrite: got reg=%h strobes=%0d want f0/0", en_reg_out_7_0, strobe_cnt - s0);
    end
    $display("bad_length: 15 and 17 bit frames errs=%0d", err_cnt - e0);
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    send_frame(17'h084FF, 16); gap(8);
    n_compared++;
    if (pwm_duty_cycle !== 8'hFF) begin
      n_mismatched++;
      $display("FAIL mid_pre: got %h want ff", pwm_duty_cycle);
    end
    frame_start();
    for (int i = 15; i >= 8; i--) spi_bit(16'h8411 >> i);
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    gap(1);
    n_compared++;
    if ({en_reg_out_7_0, pwm_duty_cycle} !== 16'h0) begin
      n_mismatched++;
      $display("FAIL mid_reset_clear: got %h want 0000", {en_reg_out_7_0, pwm_duty_cycle});
    end
    s0 = strobe_cnt; e0 = err_cnt;
    for (int i = 7; i >= 0; i--) spi_bit(16'h8411 >> i);
    frame_end(); gap(8);
    n_compared++;
    if (pwm_duty_cycle !== 8'h00 || strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
      n_mismatched++;
      $display("FAIL mid_discard: got duty=%h strobes=%0d errs=%0d want 00/0/0",
               pwm_duty_cycle, strobe_cnt - s0, err_cnt - e0);
    end
    send_frame(17'h08433, 16); gap(8);
    n_compared++;
    if (pwm_duty_cycle !== 8'h33) begin
      n_mismatched++;
      $display("FAIL mid_recover: got %h want 33", pwm_duty_cycle);
    end
    $display("reset_mid_frame: duty=%h", pwm_duty_cycle);
  endtask

  task automatic test_edge_collision();
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    frame_start();
    for (int i = 15; i >= 0; i--) spi_bit(16'h80A5 >> i);
    copi = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    ncs  = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    gap(8);
    n_compared++;
    if (en_reg_out_7_0 !== 8'hA5 || strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
      n_mismatched++;
      $display("FAIL collision: got reg=%h strobes=%0d errs=%0d want a5/1/0",
               en_reg_out_7_0, strobe_cnt - s0, err_cnt - e0);
    end
    $display("edge_collision: reg0=%h strobes=%0d errs=%0d", en_reg_out_7_0, strobe_cnt - s0, err_cnt - e0);
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_full_map();
    test_ignored();
    test_bad_length();
    test_reset_mid_frame();
    test_edge_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
